// File: rtl/golden_nonce_queue.sv
// Captures each new non-zero golden nonce from the miner core into a show-ahead FIFO
// with a saturating drop counter. Define GNON_TIMESTAMP_EN to store a cycle timestamp per entry.
module golden_nonce_queue #(
  parameter int DEPTH_LOG2  = 4,
  parameter int NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NONCE_WIDTH-1:0] golden_nonce_in,
  input  logic                   rd_en,
  input  logic                   clear_overflow,
  output logic                   rd_valid,
  output logic [NONCE_WIDTH-1:0] rd_data,
  output logic [DEPTH_LOG2:0]    fifo_count,
  output logic [15:0]            overflow_count
`ifdef GNON_TIMESTAMP_EN
  ,
  output logic [31:0]            rd_timestamp
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef GNON_TIMESTAMP_EN
  localparam int ENTRY_W = NONCE_WIDTH + 32;
`else
  localparam int ENTRY_W = NONCE_WIDTH;
`endif

  logic [NONCE_WIDTH-1:0] in_q;
  logic [NONCE_WIDTH-1:0] prev_q;
  logic [DEPTH_LOG2:0]    wr_ptr;
  logic [DEPTH_LOG2:0]    rd_ptr;
  logic [DEPTH_LOG2:0]    wr_ptr_next;
  logic [DEPTH_LOG2:0]    rd_ptr_next;
  logic [DEPTH_LOG2:0]    count_q;
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     head_entry;
  logic                   push_req;
  logic                   pop;
  logic                   full;
  logic                   do_write;
  logic                   drop;

  // Edge detector on the core output; zero is the core's idle value and never queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= golden_nonce_in;
      prev_q <= in_q;
    end
  end

  assign push_req = (in_q != prev_q) && (in_q != '0);
  assign full     = (count_q == FULL_COUNT);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_en && rd_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO is not a drop.
  assign do_write = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

`ifdef GNON_TIMESTAMP_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  assign wr_entry = {cnt, in_q};
`else
  assign wr_entry = in_q;
`endif

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
    end
  end

  assign wr_ptr_next = do_write ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      count_q <= wr_ptr_next - rd_ptr_next;
    end
  end

  // The clear takes effect first so a drop on the same edge still counts as one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_count <= '0;
    end else if (clear_overflow) begin
      overflow_count <= {15'd0, drop};
    end else if (drop && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

  assign head_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign rd_data    = rd_valid ? head_entry[NONCE_WIDTH-1:0] : '0;
  assign fifo_count = count_q;

`ifdef GNON_TIMESTAMP_EN
  assign rd_timestamp = rd_valid ? head_entry[ENTRY_W-1 -: 32] : '0;
`endif

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Randomised and directed bench for golden_nonce_queue with a queue-based reference model
// and a scoreboard monitor that checks every popped entry.
module tb_golden_nonce_queue;

  localparam int DL    = 4;
  localparam int NW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NW-1:0] golden_nonce_in = '0;
  logic          rd_en = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          rd_valid;
  logic [NW-1:0] rd_data;
  logic [DL:0]   fifo_count;
  logic [15:0]   overflow_count;
`ifdef GNON_TIMESTAMP_EN
  logic [31:0]   rd_timestamp;
`endif

  golden_nonce_queue #(.DEPTH_LOG2(DL), .NONCE_WIDTH(NW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .golden_nonce_in (golden_nonce_in),
    .rd_en           (rd_en),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .fifo_count      (fifo_count),
    .overflow_count  (overflow_count),
`ifdef GNON_TIMESTAMP_EN
    .rd_timestamp    (rd_timestamp),
`endif
    .clear_overflow  (clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] ts;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] pop_log[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_in = '0;
  logic [31:0] m_prev = '0;
  logic [31:0] m_cnt = '0;
  int          m_count = 0;
  int          m_ov = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what the queue does at the coming edge given the inputs now applied.
  task automatic model_edge(input logic [31:0] gn, input logic rd, input logic clr);
    bit push;
    bit do_pop;
    bit dropped;
    push    = (m_in != m_prev) && (m_in != 0);
    do_pop  = rd && (m_count > 0);
    dropped = 1'b0;
    if (push) begin
      if (m_count < DEPTH || do_pop) begin
        sb.push_back('{m_in, m_cnt});
        m_count++;
      end else begin
        dropped = 1'b1;
      end
    end
    if (do_pop) m_count--;
    if (clr) m_ov = dropped ? 1 : 0;
    else if (dropped && m_ov < 65535) m_ov++;
    m_prev = m_in;
    m_in   = gn;
    m_cnt  = m_cnt + 32'd1;
  endtask

  task automatic check_output();
    check("fifo_count", 64'(fifo_count), 64'(m_count));
    check("overflow_count", 64'(overflow_count), 64'(m_ov));
    check("rd_valid", 64'(rd_valid), 64'(m_count > 0));
    if (m_count > 0 && sb.size() > 0) begin
      check("rd_data_head", 64'(rd_data), 64'(sb[0].data));
`ifdef GNON_TIMESTAMP_EN
      check("rd_timestamp_head", 64'(rd_timestamp), 64'(sb[0].ts));
`endif
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] gn, input logic rd, input logic clr);
    @(negedge clk);
    check_output();
    golden_nonce_in = gn;
    rd_en           = rd;
    clear_overflow  = clr;
    model_edge(gn, rd, clr);
  endtask

  // Assert reset between edges, then release on a falling edge.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_fifo_count", 64'(fifo_count), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_overflow", 64'(overflow_count), 64'd0);
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    sb.delete();
    m_in = '0; m_prev = '0; m_cnt = '0; m_count = 0; m_ov = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_edge(golden_nonce_in, rd_en, clear_overflow);
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && rd_en && rd_valid) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("pop_data", 64'(rd_data), 64'(e.data));
`ifdef GNON_TIMESTAMP_EN
          check("pop_timestamp", 64'(rd_timestamp), 64'(e.ts));
`endif
          pop_log.push_back(rd_data);
        end
      end
    end
  end

  initial begin
    logic [31:0] vals[$];
    apply_reset();

    // Single find: two-edge latency, no repeat for a held value
    apply_stimulus(32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h1234ABCD, 1'b0, 1'b0);
    apply_stimulus(32'h1234ABCD, 1'b0, 1'b0);
    check("find_not_yet_valid", 64'(rd_valid), 64'd0);
    apply_stimulus(32'h1234ABCD, 1'b0, 1'b0);
    check("find_valid", 64'(rd_valid), 64'd1);
    check("find_data", 64'(rd_data), 64'h1234ABCD);
    for (int i = 0; i < 4; i++) apply_stimulus(32'h1234ABCD, 1'b0, 1'b0);
    check("find_no_repush", 64'(fifo_count), 64'd1);
    apply_stimulus(32'h1234ABCD, 1'b1, 1'b0);
    apply_stimulus(32'h1234ABCD, 1'b0, 1'b0);

    // Ordering with a returning value, then a pop on an empty queue
    pop_log.delete();
    apply_stimulus(32'h5, 1'b0, 1'b0);
    apply_stimulus(32'h9, 1'b0, 1'b0);
    apply_stimulus(32'h5, 1'b0, 1'b0);
    apply_stimulus(32'h5, 1'b0, 1'b0);
    apply_stimulus(32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(32'h5, 1'b1, 1'b0);
    apply_stimulus(32'h5, 1'b0, 1'b0);
    check("order_empty_valid", 64'(rd_valid), 64'd0);
    check("order_empty_count", 64'(fifo_count), 64'd0);
    check("order_n_pops", 64'(pop_log.size()), 64'd3);
    vals = '{32'h5, 32'h9, 32'h5};
    for (int i = 0; i < 3 && i < pop_log.size(); i++) check("order_value", 64'(pop_log[i]), 64'(vals[i]));

    // Fill past capacity
    for (int i = 0; i < 18; i++) apply_stimulus(32'h100 + i, 1'b0, 1'b0);
    apply_stimulus(32'h111, 1'b0, 1'b0);
    apply_stimulus(32'h111, 1'b0, 1'b0);
    check("full_count", 64'(fifo_count), 64'd16);
    check("full_overflow", 64'(overflow_count), 64'd2);

    // Clear on the same edge as another dropped push
    apply_stimulus(32'h200, 1'b0, 1'b0);
    apply_stimulus(32'h200, 1'b0, 1'b1);
    apply_stimulus(32'h200, 1'b0, 1'b0);
    check("clear_with_drop", 64'(overflow_count), 64'd1);

    // Push and pop together while full
    apply_stimulus(32'hDEADBEEF, 1'b0, 1'b0);
    apply_stimulus(32'hDEADBEEF, 1'b1, 1'b0);
    apply_stimulus(32'hDEADBEEF, 1'b0, 1'b0);
    check("pushpop_full_count", 64'(fifo_count), 64'd16);
    check("pushpop_full_ovf", 64'(overflow_count), 64'd1);
    pop_log.delete();
    for (int i = 0; i < 17; i++) apply_stimulus(32'hDEADBEEF, 1'b1, 1'b0);
    apply_stimulus(32'hDEADBEEF, 1'b0, 1'b0);
    check("drain_pops", 64'(pop_log.size()), 64'd16);
    if (pop_log.size() > 0) begin
      check("drain_first", 64'(pop_log[0]), 64'h101);
      check("drain_last", 64'(pop_log[pop_log.size()-1]), 64'hDEADBEEF);
    end

    // Reset while entries are queued and the core output is held
    apply_stimulus(32'h11, 1'b0, 1'b0);
    apply_stimulus(32'h22, 1'b0, 1'b0);
    apply_stimulus(32'h33, 1'b0, 1'b0);
    apply_stimulus(32'hCAFEF00D, 1'b0, 1'b0);
    apply_stimulus(32'hCAFEF00D, 1'b0, 1'b0);
    apply_reset();
    apply_stimulus(32'hCAFEF00D, 1'b0, 1'b0);
    apply_stimulus(32'hCAFEF00D, 1'b0, 1'b0);
    check("rst_requeue_valid", 64'(rd_valid), 64'd1);
    check("rst_requeue_data", 64'(rd_data), 64'hCAFEF00D);
    apply_stimulus(32'hCAFEF00D, 1'b0, 1'b0);
    check("rst_requeue_once", 64'(fifo_count), 64'd1);

`ifdef GNON_TIMESTAMP_EN
    // Value captured at edge 100 after release carries timestamp 100
    golden_nonce_in = '0;
    apply_reset();
    for (int i = 0; i < 98; i++) apply_stimulus(32'h0, 1'b0, 1'b0);
    apply_stimulus(32'hA5A5A5A5, 1'b0, 1'b0);
    apply_stimulus(32'hA5A5A5A5, 1'b0, 1'b0);
    apply_stimulus(32'h5A5A5A5A, 1'b0, 1'b0);
    check("ts_cycle100", 64'(rd_timestamp), 64'd100);
    apply_stimulus(32'h5A5A5A5A, 1'b1, 1'b0);
    apply_stimulus(32'h5A5A5A5A, 1'b0, 1'b0);
    check("ts_after_pop", 64'(rd_timestamp), 64'd102);
`endif

    // Randomised traffic with bursty reads
    for (int i = 0; i < 600; i++) begin
      logic [31:0] gn;
      logic        rd;
      logic        clr;
      gn  = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0) gn = golden_nonce_in;
      rd  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 30) == 0);
      apply_stimulus(gn, rd, clr);
    end
    for (int i = 0; i < 20; i++) apply_stimulus(golden_nonce_in, 1'b1, 1'b0);
    apply_stimulus(golden_nonce_in, 1'b0, 1'b0);
    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
